inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the CPU fetch port (PC in, INSTRUCTION out) and stalls the CPU through BUSYWAIT on a miss. On a miss it refills a whole 16-byte line from slow instruction memory through a read/busywait handshake. It sits between the `cpu` fetch path and the instruction memory model.

---
 rtl/inst_cache.sv | 128 ++++++++++++
 tb/tb_inst_cache.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_cache : direct-mapped read-only instruction cache, 16-byte lines,
//              refilled from slow memory. Optional ICACHE_STATS_EN counters.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module inst_cache #(
  parameter int ADDR_W = 10,
  parameter int LINES  = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         PC,
  output logic [31:0]         INSTRUCTION,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic [ADDR_W-5:0]   MEM_ADDRESS,
  input  logic [127:0]        MEM_READDATA,
  input  logic                MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]         HIT_COUNT,
  output logic [15:0]         MISS_COUNT
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - 4 - IW;
  localparam int BW = ADDR_W - 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];
  logic [BW-1:0]    miss_addr;

  logic [IW-1:0] pc_index;
  logic [TW-1:0] pc_tag;
  logic [1:0]    pc_offset;
  logic          hit;
  logic          refill_we;
  logic [IW-1:0] fill_index;
  logic [TW-1:0] fill_tag;
  logic [127:0]  cur_line;
  logic          unused_pc_bits;

  // Bits above ADDR_W alias away; the byte-within-word bits are irrelevant.
  assign pc_offset      = PC[3:2];
  assign pc_index       = PC[3+IW:4];
  assign pc_tag         = PC[ADDR_W-1:4+IW];
  assign unused_pc_bits = ^{PC[31:ADDR_W], PC[1:0]};

  assign hit        = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign fill_index = miss_addr[IW-1:0];
  assign fill_tag   = miss_addr[BW-1:IW];
  assign refill_we  = (state == S_MEM_READ) && !MEM_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (!hit) state_next = S_MEM_READ;
      S_MEM_READ: if (!MEM_BUSYWAIT) state_next = S_UPDATE;
      S_UPDATE:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      if (state == S_IDLE && !hit) begin
        miss_addr <= {pc_tag, pc_index};
      end
      if (refill_we) begin
        valid[fill_index] <= 1'b1;
      end
    end
  end

  // Line storage needs no reset: the valid bits alone qualify it.
  always_ff @(posedge CLK) begin
    if (refill_we) begin
      data_mem[fill_index] <= MEM_READDATA;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

  assign cur_line    = data_mem[pc_index];
  assign INSTRUCTION = RESET ? cur_line[{pc_offset, 5'b00000} +: 32] : 32'd0;
  assign BUSYWAIT    = RESET && ((state != S_IDLE) || !hit);
  assign MEM_READ    = (state == S_MEM_READ);
  assign MEM_ADDRESS = (state == S_MEM_READ) ? miss_addr : '0;

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HIT_COUNT  <= 16'd0;
      MISS_COUNT <= 16'd0;
    end else if (state == S_IDLE) begin
      if (hit) begin
        if (HIT_COUNT != 16'hFFFF) HIT_COUNT <= HIT_COUNT + 16'd1;
      end else begin
        if (MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_cache : directed bench for inst_cache with a latency-programmable
//                 line memory whose word at byte address A holds value A.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_inst_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  pc = 32'd0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int cnt   = 0;
  bit junk_busy = 1'b0;
  logic [31:0] base;

  inst_cache #(.ADDR_W(10), .LINES(8)) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .PC           (pc),
    .INSTRUCTION  (instruction),
    .BUSYWAIT     (busywait),
    .MEM_READ     (mem_read),
    .MEM_ADDRESS  (mem_address),
    .MEM_READDATA (mem_readdata),
    .MEM_BUSYWAIT (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (hit_count),
    .MISS_COUNT   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory holds MEM_BUSYWAIT for 'lat' edges of MEM_READ; junk_busy only
  // toggles it outside a read to show it is ignored there.
  always_ff @(posedge clk) begin
    if (!mem_read) cnt <= 0;
    else if (cnt < lat) cnt <= cnt + 1;
  end
  assign mem_busywait = junk_busy | (mem_read && (cnt < lat));

  always_comb begin
    base = {22'd0, mem_address, 4'd0};
    mem_readdata = {base + 32'd12, base + 32'd8, base + 32'd4, base};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called in the miss-detect cycle; walks the refill until BUSYWAIT falls.
  task automatic miss_seq(input logic [5:0] ea, input int l, input logic [31:0] ei);
    int bw = 0;
    int rd = 0;
    int bad_addr = 0;
    int guard = 0;
    while (busywait === 1'b1 && guard < 200) begin
      bw++;
      if (mem_read === 1'b1) begin
        rd++;
        if (mem_address !== ea) bad_addr++;
      end
      step();
      guard++;
    end
    check("miss_busy_cycles", bw, l + 3);
    check("miss_read_cycles", rd, l + 1);
    check("miss_addr_errors", bad_addr, 0);
    check("miss_instr", instruction, ei);
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          miss;
    int          lat;
    logic [5:0]  addr;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int rd;
    int bad_addr;
    int guard;

    vecs[0] = '{32'h0000_0004, 1'b0, 0, 6'h00, 32'h0000_0004};
    vecs[1] = '{32'h0000_0008, 1'b0, 0, 6'h00, 32'h0000_0008};
    vecs[2] = '{32'h0000_000C, 1'b0, 0, 6'h00, 32'h0000_000C};
    vecs[3] = '{32'h0000_0402, 1'b0, 0, 6'h00, 32'h0000_0000};
    vecs[4] = '{32'h0000_0080, 1'b1, 1, 6'h08, 32'h0000_0080};
    vecs[5] = '{32'h0000_008C, 1'b0, 0, 6'h00, 32'h0000_008C};
    vecs[6] = '{32'h0000_0000, 1'b1, 0, 6'h00, 32'h0000_0000};
    vecs[7] = '{32'h0000_03FC, 1'b1, 3, 6'h3F, 32'h0000_03FC};
    vecs[8] = '{32'h0000_03F4, 1'b0, 0, 6'h00, 32'h0000_03F4};
    vecs[9] = '{32'hFFFF_F408, 1'b0, 0, 6'h00, 32'h0000_0008};

    // Reset state
    lat = 2;
    repeat (2) step();
    check("rst_busywait", busywait, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_instruction", instruction, 0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
`endif

    // Cold miss at PC=0, L=2
    rst_n = 1'b1;
    #1;
    check("cold_detect_busy", busywait, 1);
    check("cold_detect_memrd", mem_read, 0);
    miss_seq(6'h00, 2, 32'h0);
    step();

    // Table: hits, conflicts, aliasing
    for (int i = 0; i < 10; i++) begin
      pc = vecs[i].pc;
      junk_busy = !vecs[i].miss;
      #1;
      if (vecs[i].miss) begin
        check("vec_miss_detect", busywait, 1);
        junk_busy = 1'b0;
        lat = vecs[i].lat;
        miss_seq(vecs[i].addr, vecs[i].lat, vecs[i].instr);
      end else begin
        check("vec_hit_busy", busywait, 0);
        check("vec_hit_memrd", mem_read, 0);
        check("vec_hit_instr", instruction, vecs[i].instr);
        step();
      end
`ifdef ICACHE_STATS_EN
      if (i == 2) begin
        check("stats_hit_count", hit_count, 4);
        check("stats_miss_count", miss_count, 1);
      end
`endif
    end
    junk_busy = 1'b0;

    // Reset asserted in the second MEM_READ cycle
    pc = 32'h0000_0050;
    lat = 3;
    #1;
    check("midrst_detect", busywait, 1);
    step();
    check("midrst_rd1", mem_read, 1);
    step();
    check("midrst_rd2", mem_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_memrd", mem_read, 0);
    check("midrst_busy", busywait, 0);
    check("midrst_addr", mem_address, 0);
    check("midrst_instr", instruction, 0);
`ifdef ICACHE_STATS_EN
    check("midrst_hit_count", hit_count, 0);
    check("midrst_miss_count", miss_count, 0);
`endif
    step();
    step();
    pc = 32'h0;
    rst_n = 1'b1;
    #1;
    check("postrst_pc0_miss", busywait, 1);
    lat = 0;
    miss_seq(6'h00, 0, 32'h0);
    pc = 32'h0000_0054;
    #1;
    check("postrst_line5_miss", busywait, 1);
    lat = 1;
    miss_seq(6'h05, 1, 32'h0000_0054);

    // PC changes while the refill is in flight
    pc = 32'h0000_0010;
    lat = 2;
    #1;
    check("pcchg_detect", busywait, 1);
    step();
    pc = 32'h0000_0020;
    rd = 0;
    bad_addr = 0;
    guard = 0;
    while (mem_read === 1'b1 && guard < 50) begin
      rd++;
      if (mem_address !== 6'h01) bad_addr++;
      step();
      guard++;
    end
    check("pcchg_read_cycles", rd, 3);
    check("pcchg_addr_errors", bad_addr, 0);
    check("pcchg_update_busy", busywait, 1);
    step();
    check("pcchg_idle_busy", busywait, 1);
    check("pcchg_idle_memrd", mem_read, 0);
    miss_seq(6'h02, 2, 32'h0000_0020);
    pc = 32'h0000_0014;
    #1;
    check("pcchg_line1_busy", busywait, 0);
    check("pcchg_line1_instr", instruction, 32'h0000_0014);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
